// File: rtl/logic_axi4_lite_bus_pkg.sv
// Shared AXI4-Lite bus definitions: response codes, field widths and the
// per-slave address map entry used by the read/write decoders.
package logic_axi4_lite_bus_pkg;

   localparam int RESPONSE_WIDTH = 2;
   localparam int PROT_WIDTH     = 3;

   typedef enum logic [RESPONSE_WIDTH-1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } response_t;

   // Inclusive address window; address_low > address_high marks an unused entry.
   typedef struct packed {
      logic [63:0] address_high;
      logic [63:0] address_low;
   } slave_t;

   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/logic_axi4_lite_bus_address_decode.sv
// Combinational address-map lookup: one-hot select, binary index and hit flag.
// Overlapping windows resolve to the lowest slave index.
module logic_axi4_lite_bus_address_decode
   import logic_axi4_lite_bus_pkg::*;
#(
   parameter int                  SLAVES        = 2,
   parameter int                  ADDRESS_WIDTH = 32,
   parameter int                  INDEX_WIDTH   = index_width(SLAVES),
   parameter slave_t [SLAVES-1:0] MAP           = '0
) (
   input  logic [ADDRESS_WIDTH-1:0] addr,
   output logic [SLAVES-1:0]        select,
   output logic [INDEX_WIDTH-1:0]   index,
   output logic                     hit
);

   logic [63:0] addr_ext;

   // Scan from the top down so the lowest matching index is the last one written.
   always_comb begin
      addr_ext = 64'(addr);
      select   = '0;
      index    = '0;
      hit      = 1'b0;
      for (int i = SLAVES - 1; i >= 0; i--) begin
         if ((MAP[i].address_low <= MAP[i].address_high) &&
             (addr_ext >= MAP[i].address_low) &&
             (addr_ext <= MAP[i].address_high)) begin
            select    = '0;
            select[i] = 1'b1;
            index     = INDEX_WIDTH'(i);
            hit       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/logic_axi4_lite_bus_read_decoder.sv
// AXI4-Lite read-path decoder: one master to SLAVES slaves, one read in flight,
// local DECERR for unmapped addresses. Optional LOGIC_AXI4_LITE_BUS_READ_DECODER_STATS_EN adds counters.
module logic_axi4_lite_bus_read_decoder
   import logic_axi4_lite_bus_pkg::*;
#(
   parameter int                  SLAVES        = 2,
   parameter int                  ADDRESS_WIDTH = 32,
   parameter int                  DATA_WIDTH    = 32,
   parameter slave_t [SLAVES-1:0] MAP           = '0
) (
   input  logic                             aclk,
   input  logic                             areset_n,
   input  logic                             m_arvalid,
   output logic                             m_arready,
   input  logic [ADDRESS_WIDTH-1:0]         m_araddr,
   input  logic [PROT_WIDTH-1:0]            m_arprot,
   output logic                             m_rvalid,
   input  logic                             m_rready,
   output logic [DATA_WIDTH-1:0]            m_rdata,
   output logic [RESPONSE_WIDTH-1:0]        m_rresp,
   output logic [SLAVES-1:0]                s_arvalid,
   input  logic [SLAVES-1:0]                s_arready,
   output logic [ADDRESS_WIDTH-1:0]         s_araddr,
   output logic [PROT_WIDTH-1:0]            s_arprot,
   input  logic [SLAVES-1:0]                s_rvalid,
   output logic [SLAVES-1:0]                s_rready,
   input  logic [SLAVES*DATA_WIDTH-1:0]     s_rdata,
   input  logic [SLAVES*RESPONSE_WIDTH-1:0] s_rresp
`ifdef LOGIC_AXI4_LITE_BUS_READ_DECODER_STATS_EN
   ,
   output logic [31:0]                      accepted_count,
   output logic [31:0]                      decerr_count
`endif
);

   localparam int INDEX_WIDTH = index_width(SLAVES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_DECERR
   } state_t;

   state_t                 state, state_next;
   logic [SLAVES-1:0]      sel_oh;
   logic [INDEX_WIDTH-1:0] sel_idx;
   logic [SLAVES-1:0]      dec_select;
   logic [INDEX_WIDTH-1:0] dec_index;
   logic                   dec_hit;
   logic                   ar_hs;

   logic_axi4_lite_bus_address_decode #(
      .SLAVES        (SLAVES),
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .INDEX_WIDTH   (INDEX_WIDTH),
      .MAP           (MAP)
   ) u_address_decode (
      .addr   (m_araddr),
      .select (dec_select),
      .index  (dec_index),
      .hit    (dec_hit)
   );

   assign ar_hs = m_arvalid && m_arready;

   // Outputs are decoded from the registered state; the DATA phase is a pure
   // combinational pass-through of the selected slave.
   always_comb begin
      state_next = state;
      s_arvalid  = '0;
      s_rready   = '0;
      m_rvalid   = 1'b0;
      m_rdata    = '0;
      m_rresp    = '0;
      case (state)
         ST_IDLE: begin
            if (ar_hs) begin
               state_next = dec_hit ? ST_ADDR : ST_DECERR;
            end
         end
         ST_ADDR: begin
            s_arvalid = sel_oh;
            if (|(s_arready & sel_oh)) begin
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            m_rvalid = |(s_rvalid & sel_oh);
            m_rdata  = s_rdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
            m_rresp  = s_rresp[sel_idx*RESPONSE_WIDTH +: RESPONSE_WIDTH];
            s_rready = sel_oh & {SLAVES{m_rready}};
            if (m_rvalid && m_rready) begin
               state_next = ST_IDLE;
            end
         end
         ST_DECERR: begin
            m_rvalid = 1'b1;
            m_rresp  = DECERR;
            if (m_rready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // m_arready is registered so it only rises once the decoder is back in IDLE.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state     <= ST_IDLE;
         m_arready <= 1'b0;
         s_araddr  <= '0;
         s_arprot  <= '0;
         sel_oh    <= '0;
         sel_idx   <= '0;
      end else begin
         state     <= state_next;
         m_arready <= (state_next == ST_IDLE);
         if (ar_hs) begin
            s_araddr <= m_araddr;
            s_arprot <= m_arprot;
            sel_oh   <= dec_select;
            sel_idx  <= dec_index;
         end
      end
   end

`ifdef LOGIC_AXI4_LITE_BUS_READ_DECODER_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         accepted_count <= '0;
         decerr_count   <= '0;
      end else begin
         if (ar_hs) begin
            accepted_count <= sat_inc(accepted_count);
         end
         if ((state == ST_DECERR) && m_rvalid && m_rready) begin
            decerr_count <= sat_inc(decerr_count);
         end
      end
   end
`endif

endmodule
